// File: rtl/handshake_receiver.sv
// Receive side of the valid/ready byte stream: buffers accepted beats in a FWFT FIFO,
// checks the incrementing payload sequence and keeps saturating beat/error statistics.
module handshake_receiver #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              random_ready,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   input  logic              drain_en,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] expected_o,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_flag
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  count_q, count_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] expected_q, expected_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              err_flag_q, err_flag_d;
   logic              push, pop;

   always_comb begin
      push       = valid_i & ready_q;
      pop        = drain_en & (count_q != '0);
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      expected_d = expected_q;
      beat_cnt_d = beat_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;

      // Pointers wrap naturally because FIFO_DEPTH is a power of two
      if (push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);

      // Ready looks at next occupancy so a push can never land on a full FIFO
      ready_d = random_ready & (count_d < DEPTH_C);

      if (push) begin
         if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
         if (data_i == expected_q) begin
            expected_d = expected_q + DATA_W'(1);
         end else begin
            expected_d = data_i + DATA_W'(1);
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_q    <= 1'b0;
         expected_q <= DATA_W'(1);
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         expected_q <= expected_d;
         beat_cnt_q <= beat_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
      end
   end

   assign ready_o    = ready_q;
   assign out_valid  = (count_q != '0);
   assign out_data   = mem_q[rd_ptr_q];
   assign expected_o = expected_q;
   assign beat_cnt   = beat_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_handshake_receiver.sv
// Bench for handshake_receiver: a vector table for the sequence-error case, directed
// full/reset sequences, and random traffic against a queue-based reference model.
module tb_handshake_receiver;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              random_ready = 1'b0;
   logic              valid_i = 1'b0;
   logic [DATA_W-1:0] data_i = '0;
   logic              drain_en = 1'b0;
   logic              ready_o;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] expected_o;
   logic [CNT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic              err_flag;

   handshake_receiver #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .random_ready(random_ready), .valid_i(valid_i),
      .data_i(data_i), .ready_o(ready_o), .drain_en(drain_en), .out_valid(out_valid),
      .out_data(out_data), .expected_o(expected_o), .beat_cnt(beat_cnt),
      .err_cnt(err_cnt), .err_flag(err_flag)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: the buffer is a plain queue, statistics are plain integers
   byte unsigned mq[$];
   bit m_ready;
   int m_exp, m_beat, m_err;
   bit m_flag;
   int seq;

   typedef struct {
      bit         rr, v, drain;
      logic [7:0] d;
      bit         e_ready, e_ov;
      logic [7:0] e_od, e_exp;
      int         e_err;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ready = 0; m_exp = 1; m_beat = 0; m_err = 0; m_flag = 0; seq = 1;
   endtask

   task automatic check_outputs();
      chk("ready_o", 32'(ready_o), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
      chk("expected_o", 32'(expected_o), 32'(m_exp));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_beat));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("err_flag", 32'(err_flag), 32'(m_flag));
   endtask

   // One clock: sender drives seq when enabled, model advances, outputs compared
   task automatic step(input bit sender);
      bit push, pop;
      if (sender) data_i = 8'(seq);
      if (valid_i && mq.size() == FIFO_DEPTH) chk("push_while_full", 32'(ready_o), 0);
      push = valid_i & m_ready;
      pop  = drain_en & (mq.size() != 0);
      @(posedge clk); #1;
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(data_i);
         if (m_beat < 65535) m_beat++;
         if (int'(data_i) == m_exp) m_exp = (m_exp + 1) % 256;
         else begin
            if (m_err < 65535) m_err++;
            m_flag = 1;
            m_exp = (int'(data_i) + 1) % 256;
         end
         if (sender) seq = (seq + 1) % 256;
      end
      m_ready = random_ready && (mq.size() < FIFO_DEPTH);
      check_outputs();
   endtask

   task automatic apply_reset(input int cycles);
      reset_n = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         random_ready = 1'($urandom); valid_i = 1'($urandom);
         drain_en = 1'($urandom); data_i = 8'($urandom);
         @(posedge clk); #1;
         chk("rst_ready_o", 32'(ready_o), 0);
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_out_data", 32'(out_data), 0);
         chk("rst_expected_o", 32'(expected_o), 1);
         chk("rst_beat_cnt", 32'(beat_cnt), 0);
         chk("rst_err_cnt", 32'(err_cnt), 0);
         chk("rst_err_flag", 32'(err_flag), 0);
      end
      random_ready = 0; valid_i = 0; drain_en = 0; data_i = '0;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] last_od;
      bit         have_last, wrap_seen;

      //            rr v  drain d     rdy ov od    exp   err
      tbl[0] = '{1, 0, 0, 8'd0, 1, 0, 8'd0, 8'd1, 0};
      tbl[1] = '{1, 1, 0, 8'd1, 1, 1, 8'd1, 8'd2, 0};
      tbl[2] = '{1, 1, 1, 8'd2, 1, 1, 8'd2, 8'd3, 0};
      tbl[3] = '{1, 1, 1, 8'd7, 1, 1, 8'd7, 8'd8, 1};
      tbl[4] = '{1, 1, 1, 8'd8, 1, 1, 8'd8, 8'd9, 1};
      tbl[5] = '{1, 0, 1, 8'd0, 1, 0, 8'd0, 8'd9, 1};

      #2;
      apply_reset(3);

      // Sequence error 1,2,7,8
      for (int i = 0; i < 6; i++) begin
         random_ready = tbl[i].rr; valid_i = tbl[i].v;
         drain_en = tbl[i].drain; data_i = tbl[i].d;
         @(posedge clk); #1;
         chk("tbl_ready_o", 32'(ready_o), 32'(tbl[i].e_ready));
         chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) chk("tbl_out_data", 32'(out_data), 32'(tbl[i].e_od));
         chk("tbl_expected_o", 32'(expected_o), 32'(tbl[i].e_exp));
         chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].e_err));
      end
      chk("tbl_err_flag", 32'(err_flag), 1);
      chk("tbl_beat_cnt", 32'(beat_cnt), 4);

      // Streaming at full throughput across the 255->0 wrap
      apply_reset(2);
      random_ready = 1; valid_i = 1; drain_en = 1;
      have_last = 0; wrap_seen = 0; last_od = '0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (out_valid) begin
            if (have_last && last_od == 8'd255 && out_data == 8'd0) wrap_seen = 1;
            last_od = out_data; have_last = 1;
         end
      end
      chk("stream_wrap", 32'(wrap_seen), 1);
      chk("stream_beats", 32'(beat_cnt), 299);
      chk("stream_err", 32'(err_cnt), 0);

      // Fill to full, stall, single pop, resume
      apply_reset(2);
      random_ready = 1; valid_i = 1; drain_en = 0;
      for (int i = 0; i < 5; i++) step(1);
      chk("full_ready_low", 32'(ready_o), 0);
      chk("full_beats", 32'(beat_cnt), 4);
      step(1);
      chk("full_hold_data", 32'(data_i), 5);
      chk("full_beats_stalled", 32'(beat_cnt), 4);
      drain_en = 1;
      step(1);
      chk("pop_next_head", 32'(out_data), 2);
      chk("pop_ready_back", 32'(ready_o), 1);
      drain_en = 0;
      step(1);
      chk("resume_beats", 32'(beat_cnt), 5);
      chk("resume_ready_low", 32'(ready_o), 0);

      // Random traffic
      apply_reset(2);
      for (int i = 0; i < 10000; i++) begin
         random_ready = 1'($urandom); valid_i = 1'($urandom); drain_en = 1'($urandom);
         step(1);
      end
      chk("rand_err_cnt", 32'(err_cnt), 0);
      chk("rand_err_flag", 32'(err_flag), 0);

      // Reset in the middle of a transfer with three entries buffered
      apply_reset(2);
      random_ready = 1; valid_i = 1; drain_en = 0;
      for (int i = 0; i < 4; i++) step(1);
      chk("mid_occupied", 32'(out_valid), 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_out_valid", 32'(out_valid), 0);
      chk("mid_beat_cnt", 32'(beat_cnt), 0);
      chk("mid_expected_o", 32'(expected_o), 1);
      chk("mid_ready_o", 32'(ready_o), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
      random_ready = 1; valid_i = 1; drain_en = 1;
      for (int i = 0; i < 20; i++) step(1);
      chk("mid_restart_err", 32'(err_cnt), 0);
      chk("mid_restart_beats", 32'(beat_cnt), 19);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
